// File: rtl/ascon_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ascon_pkg : shared rate sizes, padding byte and FSM encoding for padder      |
// | Revision  : 1.0                                                             |
// +----------------------------------------------------------------------------+
package ascon_pkg;

  localparam int unsigned RATE_BYTES_128  = 8;
  localparam int unsigned RATE_BYTES_128A = 16;
  localparam logic [7:0]  PAD_BYTE        = 8'h80;

  typedef enum logic [1:0] {
    ST_FILL     = 2'd0,
    ST_EMIT     = 2'd1,
    ST_PAD_EMIT = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/ascon_pad_insert.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ascon_pad_insert : keeps bytes below count, drops PAD_BYTE at count, aligns  |
// | the result to the active rate of the category. Revision 1.0                 |
// +----------------------------------------------------------------------------+
module ascon_pad_insert
  import ascon_pkg::*;
#(
  parameter int RATE_MAX_W = 128,
  parameter int IW         = $clog2(RATE_MAX_W / 8) + 1
) (
  input  logic [RATE_MAX_W-1:0] src,
  input  logic [IW-1:0]         count,
  input  logic                  pad_en,
  input  logic                  category,
  output logic [RATE_MAX_W-1:0] block
);

  localparam int MAXB  = RATE_MAX_W / 8;
  localparam int SHIFT = RATE_MAX_W - 8 * RATE_BYTES_128;

  logic [IW-1:0]         rate_bytes;
  logic [RATE_MAX_W-1:0] wide;

  assign rate_bytes = category ? IW'(RATE_BYTES_128A) : IW'(RATE_BYTES_128);

  // src is always laid out MSB-first across the full width; byte i is byte i of the message
  for (genvar i = 0; i < MAXB; i++) begin : g_byte
    localparam logic [IW-1:0] BI = IW'(i);
    logic [7:0] b;
    always_comb begin
      b = 8'h00;
      if (BI < rate_bytes) begin
        if (BI < count) begin
          b = src[RATE_MAX_W-1-8*i -: 8];
        end else if (pad_en && (BI == count)) begin
          b = PAD_BYTE;
        end
      end
    end
    assign wide[RATE_MAX_W-1-8*i -: 8] = b;
  end

  // The narrow rate lives in the low bits of the block
  assign block = category ? wide : (wide >> SHIFT);

endmodule
`default_nettype wire

// File: rtl/ascon_block_padder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ascon_block_padder : packs a byte stream into padded ASCON rate blocks.      |
// | Option macro ASCON_BLK_CNT_EN adds blk_count. Revision 1.0                   |
// +----------------------------------------------------------------------------+
module ascon_block_padder
  import ascon_pkg::*;
#(
  parameter int RATE_MAX_W = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  permutation_category,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  input  logic                  in_empty,
  output logic                  in_ready,
  output logic [RATE_MAX_W-1:0] data_block,
  output logic                  blk_valid,
  output logic                  blk_last,
  output logic                  blk_category,
  input  logic                  blk_ready
`ifdef ASCON_BLK_CNT_EN
  ,
  output logic [15:0]           blk_count
`endif
);

  localparam int MAXB = RATE_MAX_W / 8;
  localparam int IW   = $clog2(MAXB) + 1;

  localparam logic [1:0] FILL     = ST_FILL;
  localparam logic [1:0] EMIT     = ST_EMIT;
  localparam logic [1:0] PAD_EMIT = ST_PAD_EMIT;

  logic [1:0]            state;
  logic [IW-1:0]         idx;
  logic [RATE_MAX_W-1:0] buffer;
  logic                  active;
  logic                  cat_q;
  logic                  pad_pend;

  logic                  cat_eff;
  logic [IW-1:0]         rate_bytes;
  logic                  full;
  logic                  byte_beat;
  logic                  emit;
  logic                  last_blk;
  logic                  hs;
  logic [RATE_MAX_W-1:0] merged;
  logic [RATE_MAX_W-1:0] pi_src;
  logic [IW-1:0]         pi_count;
  logic                  pi_pad;
  logic [RATE_MAX_W-1:0] padded;

  // The first beat of a message sees the live category; later beats use the latched one
  assign cat_eff    = active ? cat_q : permutation_category;
  assign rate_bytes = cat_eff ? IW'(RATE_BYTES_128A) : IW'(RATE_BYTES_128);
  assign full       = (idx == rate_bytes - IW'(1));

  assign in_ready     = (state == FILL);
  assign blk_valid    = (state != FILL);
  assign blk_category = cat_q;
  assign hs           = blk_valid && blk_ready;

  assign byte_beat = (state == FILL) && !in_empty;
  assign emit      = in_empty ? in_last : (full || in_last);
  assign last_blk  = in_empty || !full;

  for (genvar i = 0; i < MAXB; i++) begin : g_merge
    localparam logic [IW-1:0] BI = IW'(i);
    assign merged[RATE_MAX_W-1-8*i -: 8] =
      (idx == BI) ? in_data : buffer[RATE_MAX_W-1-8*i -: 8];
  end

  // Outside FILL the buffer and idx are zero, so the same path yields the pad-only block
  assign pi_src   = byte_beat ? merged : buffer;
  assign pi_count = byte_beat ? (idx + IW'(1)) : idx;
  assign pi_pad   = !(byte_beat && full);

  ascon_pad_insert #(
    .RATE_MAX_W (RATE_MAX_W),
    .IW         (IW)
  ) u_pad_insert (
    .src      (pi_src),
    .count    (pi_count),
    .pad_en   (pi_pad),
    .category (cat_eff),
    .block    (padded)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      idx        <= '0;
      buffer     <= '0;
      data_block <= '0;
      blk_last   <= 1'b0;
      cat_q      <= 1'b0;
      active     <= 1'b0;
      pad_pend   <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (in_valid && !(in_empty && !in_last)) begin
            active <= 1'b1;
            if (!active) begin
              cat_q <= permutation_category;
            end
            if (emit) begin
              data_block <= padded;
              blk_last   <= last_blk;
              pad_pend   <= in_last && !in_empty && full;
              buffer     <= '0;
              idx        <= '0;
              state      <= EMIT;
            end else begin
              buffer <= merged;
              idx    <= idx + IW'(1);
            end
          end
        end
        EMIT: begin
          if (blk_ready) begin
            if (pad_pend) begin
              data_block <= padded;
              blk_last   <= 1'b1;
              pad_pend   <= 1'b0;
              state      <= PAD_EMIT;
            end else begin
              if (blk_last) begin
                active <= 1'b0;
              end
              blk_last <= 1'b0;
              state    <= FILL;
            end
          end
        end
        PAD_EMIT: begin
          if (blk_ready) begin
            active   <= 1'b0;
            blk_last <= 1'b0;
            state    <= FILL;
          end
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

`ifdef ASCON_BLK_CNT_EN
  logic [15:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (hs) begin
      if (blk_last) begin
        cnt <= '0;
      end else if (cnt != 16'hFFFF) begin
        cnt <= cnt + 16'd1;
      end
    end
  end

  assign blk_count = cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ascon_block_padder.sv
`default_nettype none
// Directed bench for ascon_block_padder: table of whole messages plus stall, toggle and reset sequences.
module tb_ascon_block_padder;

  logic         clk;
  logic         rst;
  logic         permutation_category;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_empty;
  logic         in_ready;
  logic [127:0] data_block;
  logic         blk_valid;
  logic         blk_last;
  logic         blk_category;
  logic         blk_ready;
`ifdef ASCON_BLK_CNT_EN
  logic [15:0]  blk_count;
`endif

  ascon_block_padder #(.RATE_MAX_W(128)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .permutation_category (permutation_category),
    .in_data              (in_data),
    .in_valid             (in_valid),
    .in_last              (in_last),
    .in_empty             (in_empty),
    .in_ready             (in_ready),
    .data_block           (data_block),
    .blk_valid            (blk_valid),
    .blk_last             (blk_last),
    .blk_category         (blk_category),
    .blk_ready            (blk_ready)
`ifdef ASCON_BLK_CNT_EN
    ,
    .blk_count            (blk_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] d;
    logic         l;
    logic         c;
  } blk_t;

  typedef struct {
    logic         cat;
    int           n;
    logic         empty;
    int           nblk;
    logic [127:0] e0;
    logic         l0;
    logic [127:0] e1;
  } vec_t;

  blk_t q[$];
  vec_t v[9];
  int   checks = 0;
  int   errors = 0;

  always @(negedge clk) begin
    if (!rst && blk_valid && blk_ready) begin
      q.push_back('{d: data_block, l: blk_last, c: blk_category});
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called and returning just after a rising edge
  task automatic send_beat(input logic [7:0] d, input logic last, input logic empty);
    int t;
    t = 0;
    in_data  = d;
    in_last  = last;
    in_empty = empty;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 50);
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_beat: in_ready got 0 expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_empty = 1'b0;
  endtask

  task automatic collect(input string nm, input int n);
    int t;
    t = 0;
    while (q.size() < n && t < 40) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk({nm, "_nblk"}, 128'(q.size()), 128'(n));
    @(posedge clk);
    #1;
  endtask

  initial begin
    v[0] = '{cat: 1'b0, n: 5,  empty: 1'b0, nblk: 1, e0: {64'h0, 64'h0102030405800000}, l0: 1'b1, e1: '0};
    v[1] = '{cat: 1'b0, n: 8,  empty: 1'b0, nblk: 2, e0: {64'h0, 64'h0102030405060708}, l0: 1'b0,
             e1: {64'h0, 64'h8000000000000000}};
    v[2] = '{cat: 1'b1, n: 0,  empty: 1'b1, nblk: 1, e0: {8'h80, 120'h0}, l0: 1'b1, e1: '0};
    v[3] = '{cat: 1'b0, n: 1,  empty: 1'b0, nblk: 1, e0: {64'h0, 64'h0180000000000000}, l0: 1'b1, e1: '0};
    v[4] = '{cat: 1'b1, n: 16, empty: 1'b0, nblk: 2, e0: 128'h0102030405060708090a0b0c0d0e0f10, l0: 1'b0,
             e1: {8'h80, 120'h0}};
    v[5] = '{cat: 1'b1, n: 15, empty: 1'b0, nblk: 1, e0: 128'h0102030405060708090a0b0c0d0e0f80, l0: 1'b1, e1: '0};
    v[6] = '{cat: 1'b0, n: 7,  empty: 1'b0, nblk: 1, e0: {64'h0, 64'h0102030405060780}, l0: 1'b1, e1: '0};
    v[7] = '{cat: 1'b0, n: 0,  empty: 1'b1, nblk: 1, e0: {64'h0, 64'h8000000000000000}, l0: 1'b1, e1: '0};
    v[8] = '{cat: 1'b0, n: 8,  empty: 1'b1, nblk: 2, e0: {64'h0, 64'h0102030405060708}, l0: 1'b0,
             e1: {64'h0, 64'h8000000000000000}};

    rst = 1'b1;
    permutation_category = 1'b0;
    in_data = 8'h00;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_empty = 1'b0;
    blk_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_blk_valid", 128'(blk_valid), 128'(0));
    chk("rst_data_block", data_block, 128'h0);
    chk("rst_blk_last", 128'(blk_last), 128'(0));
    chk("rst_blk_category", 128'(blk_category), 128'(0));
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      q.delete();
      permutation_category = v[i].cat;
      for (int k = 0; k < v[i].n; k++) begin
        send_beat(8'(k + 1), (k == v[i].n - 1) && !v[i].empty, 1'b0);
      end
      if (v[i].empty) send_beat(8'h00, 1'b1, 1'b1);
      collect($sformatf("vec%0d", i), v[i].nblk);
      if (q.size() > 0) begin
        chk($sformatf("vec%0d_blk0", i), q[0].d, v[i].e0);
        chk($sformatf("vec%0d_last0", i), 128'(q[0].l), 128'(v[i].l0));
        chk($sformatf("vec%0d_cat0", i), 128'(q[0].c), 128'(v[i].cat));
      end
      if (v[i].nblk == 2 && q.size() > 1) begin
        chk($sformatf("vec%0d_blk1", i), q[1].d, v[i].e1);
        chk($sformatf("vec%0d_last1", i), 128'(q[1].l), 128'(1));
      end
    end

    // Backpressure: cat=1, 20 bytes, downstream stalls on the first block
    q.delete();
    permutation_category = 1'b1;
    blk_ready = 1'b0;
    for (int k = 0; k < 16; k++) send_beat(8'(k + 1), 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_valid", c), 128'(blk_valid), 128'(1));
      chk($sformatf("stall%0d_in_ready", c), 128'(in_ready), 128'(0));
      chk($sformatf("stall%0d_data", c), data_block, 128'h0102030405060708090a0b0c0d0e0f10);
    end
    @(posedge clk);
    #1 blk_ready = 1'b1;
    for (int k = 16; k < 20; k++) send_beat(8'(k + 1), k == 19, 1'b0);
    collect("stall", 2);
    if (q.size() > 1) begin
      chk("stall_blk0_last", 128'(q[0].l), 128'(0));
      chk("stall_blk1", q[1].d, {32'h11121314, 8'h80, 88'h0});
      chk("stall_blk1_last", 128'(q[1].l), 128'(1));
    end

    // Category changes after the first beat must not affect this message
    q.delete();
    permutation_category = 1'b0;
    send_beat(8'h01, 1'b0, 1'b0);
    permutation_category = 1'b1;
    for (int k = 1; k < 5; k++) send_beat(8'(k + 1), k == 4, 1'b0);
    permutation_category = 1'b0;
    collect("toggle", 1);
    if (q.size() > 0) begin
      chk("toggle_blk", q[0].d, {64'h0, 64'h0102030405800000});
      chk("toggle_cat", 128'(q[0].c), 128'(0));
    end

    // in_empty without in_last is consumed and ignored
    q.delete();
    permutation_category = 1'b0;
    send_beat(8'h01, 1'b0, 1'b0);
    send_beat(8'h02, 1'b0, 1'b0);
    send_beat(8'hEE, 1'b0, 1'b1);
    send_beat(8'h03, 1'b1, 1'b0);
    collect("ign_empty", 1);
    if (q.size() > 0) chk("ign_empty_blk", q[0].d, {64'h0, 64'h0102038000000000});

    // Reset mid-message discards everything buffered
    q.delete();
    permutation_category = 1'b1;
    for (int k = 0; k < 3; k++) send_beat(8'(k + 1), 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    chk("midrst_blk_valid", 128'(blk_valid), 128'(0));
    chk("midrst_data", data_block, 128'h0);
    chk("midrst_cat", 128'(blk_category), 128'(0));
    @(posedge clk);
    #1;
    permutation_category = 1'b0;
    send_beat(8'hAA, 1'b1, 1'b0);
    @(negedge clk);
    chk("latency_valid", 128'(blk_valid), 128'(1));
    collect("midrst", 1);
    if (q.size() > 0) begin
      chk("midrst_blk", q[0].d, {64'h0, 64'hAA80000000000000});
      chk("midrst_last", 128'(q[0].l), 128'(1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ascon_block_padder.md
ASCON_BLOCK_PADDER -- requirements
Module: ascon_block_padder

Interface
REQ-001 SHALL have parameter RATE_MAX_W, default 128, meaning the widest rate in bits, i.e. the data_block width.
REQ-002 SHALL have port clk  input  1  rising-edge clock; the block has one clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port permutation_category  input  1  0 selects ASCON_128 (8-byte rate), 1 selects ASCON_128a (16-byte rate).
REQ-005 SHALL have port in_data  input  8  message byte.
REQ-006 SHALL have port in_valid  input  1  in_data is valid.
REQ-007 SHALL have port in_last  input  1  final beat of the message.
REQ-008 SHALL have port in_empty  input  1  beat carries no byte; legal only with in_last (empty message).
REQ-009 SHALL have port in_ready  output  1  byte accepted when in_valid && in_ready.
REQ-010 SHALL have port data_block  output  RATE_MAX_W  padded rate block.
REQ-011 SHALL have port blk_valid  output  1  data_block is valid.
REQ-012 SHALL have port blk_last  output  1  final (padded) block of the message.
REQ-013 SHALL have port blk_category  output  1  category latched for the current message.
REQ-014 SHALL have port blk_ready  input  1  downstream accepts when blk_valid && blk_ready.

Function
REQ-015 SHALL pack bytes MSB-first: byte 0 goes to the most significant byte of the active rate.
- ASCON_128: active rate is data_block[63:0]; bits [127:64] are 0.
- ASCON_128a: active rate is data_block[127:0].
REQ-016 SHALL latch permutation_category on the first accepted beat of a message and hold it until the blk_last handshake; later changes are ignored.
REQ-017 SHALL implement FSM states FILL, EMIT, PAD_EMIT; reset state is FILL.
REQ-018 FILL SHALL assert in_ready=1 and blk_valid=0, writing each accepted byte at byte index idx and incrementing idx.
REQ-019 Full block (idx reaches RATE_BYTES-1), accepted beat not last: SHALL go to EMIT with blk_last=0.
REQ-020 Last byte that completes a full block: SHALL go to EMIT with blk_last=0, then PAD_EMIT.
REQ-021 Last byte in a partial block: SHALL place 0x80 at idx+1, zero all lower bytes, and go to EMIT with blk_last=1.
REQ-022 Beat with in_empty=1 and in_last=1: SHALL place 0x80 at the current idx, zero the remainder, and go to EMIT with blk_last=1 (covers the empty message and the after-full-block case).
REQ-023 PAD_EMIT SHALL present 0x80 followed by zeros in the active rate, with blk_last=1.
REQ-024 EMIT and PAD_EMIT SHALL hold blk_valid=1, in_ready=0, and data_block stable until blk_ready.
REQ-025 On handshake: EMIT returns to FILL (idx=0, buffer cleared), or goes to PAD_EMIT per REQ-020; PAD_EMIT returns to FILL.
REQ-026 Latency SHALL be one cycle: blk_valid rises in the cycle after the completing beat is accepted.
REQ-027 No bubble is required after the block handshake; FILL may accept in the next cycle.
REQ-028 An in_empty beat without in_last SHALL be ignored (consumed, no state change).

Reset
REQ-029 While rst=1 at a clk edge, SHALL force state FILL, idx=0, buffer=0, data_block=0, blk_valid=0, blk_last=0, blk_category=0; in_ready SHALL read 1 in the cycle after reset deasserts.
REQ-030 Reset mid-message SHALL discard partial data and any pending block; no block is emitted.

Configuration
REQ-031 With ASCON_BLK_CNT_EN defined, SHALL add output blk_count[15:0]:
- number of blocks handshaked in the current message;
- saturates at 0xFFFF;
- cleared after the blk_last handshake and on reset.
REQ-032 Without ASCON_BLK_CNT_EN, the port and counter SHALL be absent; all other behaviour is identical.

Structure
REQ-033 Package ascon_pkg SHALL hold RATE_BYTES_128=8, RATE_BYTES_128A=16, PAD_BYTE=8'h80, and the FSM state enum.
REQ-034 SHALL instantiate one combinational sub-module ascon_pad_insert (buffer, idx, category -> padded block).

Verification
REQ-035 SHALL cover these directed scenarios:
- cat=0, bytes 01..05, last on 05 -> one block, data_block[63:0]=0x0102030405800000, blk_last=1.
- cat=0, bytes 01..08, last on 08 -> block 0x0102030405060708 (last=0), then 0x8000000000000000 (last=1).
- cat=1, empty message (in_empty+in_last) -> one block 0x80 followed by 15 zero bytes, blk_last=1.
- cat=1, 20 bytes, blk_ready held low 5 cycles -> data_block stable, in_ready=0; 2 blocks, 2nd = bytes 16..19, 0x80, zeros.
- Category toggled mid-message -> packing unchanged, blk_category = first-beat value.
- rst after 3 bytes, then cat=0 single byte AA with last -> only block 0xAA80000000000000.
